mouse_motion_accumulator: RTL and testbench

Sits between the pattern generator and the HID report manager in the 48 MHz domain. Integrates signed per-event X/Y motion deltas and button state into saturating accumulators. Once per report interval, it offers one HID-range report (−127..+127 per axis) on a valid/ready handshake. Residual motion above the HID range carries over into later reports, so no motion is lost while the host polls slower than the generator produces.

---
 rtl/mouse_pkg.sv | 8 +
 rtl/mouse_motion_accumulator_sat_accum.sv | 49 ++++
 rtl/mouse_motion_accumulator.sv | 90 +++++++++
 tb/tb_mouse_motion_accumulator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse motion accumulator.
package mouse_pkg;
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam int HID_MAX          = 127;
  localparam int HID_MIN          = -127;
  localparam int DEF_INTERVAL_CYC = 48000;
endpackage

// File: rtl/mouse_motion_accumulator_sat_accum.sv
// One axis: saturating signed accumulator with HID clamp-and-subtract on load.
module sat_accum
  import mouse_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              add,
  input  logic              load,
  input  logic signed [7:0] delta,
  output logic signed [7:0] clamped,
  output logic              sat,
  output logic              nonzero
);
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HI   = ACC_W'(HID_MAX);
  localparam logic signed [ACC_W-1:0] LO   = ACC_W'(HID_MIN);

  logic signed [ACC_W-1:0] acc, clamp_w, base, nxt;
  logic signed [ACC_W:0]   sum, dext;
  logic                    ovf_hi, ovf_lo;

  always_comb begin
    clamp_w = acc;
    if (acc > HI)      clamp_w = HI;
    else if (acc < LO) clamp_w = LO;
  end

  // The load residual and the new delta are summed in one extra bit so a
  // single clamp covers both.
  assign base    = load ? acc - clamp_w : acc;
  assign dext    = add ? (ACC_W+1)'(delta) : '0;
  assign sum     = {base[ACC_W-1], base} + dext;
  assign ovf_hi  = ~sum[ACC_W] &  sum[ACC_W-1];
  assign ovf_lo  =  sum[ACC_W] & ~sum[ACC_W-1];
  assign nxt     = ovf_hi ? MAXV : (ovf_lo ? MINV : sum[ACC_W-1:0]);
  assign sat     = ovf_hi | ovf_lo;
  assign clamped = clamp_w[7:0];
  assign nonzero = |acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (flush) acc <= '0;
    else            acc <= nxt;
  end
endmodule

// File: rtl/mouse_motion_accumulator.sv
// Integrates motion/button events and offers one HID-range report per interval.
module mouse_motion_accumulator
  import mouse_pkg::*;
#(
  parameter int ACC_W        = 16,
  parameter int INTERVAL_CYC = DEF_INTERVAL_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic signed [7:0] in_dx,
  input  logic signed [7:0] in_dy,
  input  logic [2:0]        in_buttons,
  input  logic              usb_configured,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_x,
  output logic signed [7:0] out_y,
  output logic [2:0]        out_buttons,
  output logic              sat_flag
);
  localparam int CW = (INTERVAL_CYC > 1) ? $clog2(INTERVAL_CYC) : 1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              tick_pend, wrap, pending, load, add, flush;
  logic [2:0]        btn, last_btn;
  logic signed [7:0] cx, cy;
  logic              sat_x, sat_y, nz_x, nz_y;

  assign flush   = ~usb_configured;
  assign add     = in_valid & usb_configured;
  assign wrap    = (cnt == CW'(INTERVAL_CYC - 1));
  assign pending = nz_x | nz_y | (btn != last_btn);
  assign load    = (state == IDLE) & tick_pend & pending & usb_configured;

  sat_accum #(.ACC_W(ACC_W)) u_acc_x (
    .clk(clk), .rst_n(rst_n), .flush(flush), .add(add), .load(load),
    .delta(in_dx), .clamped(cx), .sat(sat_x), .nonzero(nz_x)
  );

  sat_accum #(.ACC_W(ACC_W)) u_acc_y (
    .clk(clk), .rst_n(rst_n), .flush(flush), .add(add), .load(load),
    .delta(in_dy), .clamped(cy), .sat(sat_y), .nonzero(nz_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tick_pend   <= 1'b0;
      btn         <= '0;
      last_btn    <= '0;
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_buttons <= '0;
      sat_flag    <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (!usb_configured) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        tick_pend <= 1'b0;
        sat_flag  <= 1'b0;
        last_btn  <= '0;
      end else begin
        if (in_valid)      btn      <= in_buttons;
        if (sat_x | sat_y) sat_flag <= 1'b1;
        // A tick landing on the load cycle is kept for the next report.
        tick_pend <= (tick_pend & ~load) | wrap;
        case (state)
          IDLE: if (load) begin
            out_x       <= cx;
            out_y       <= cy;
            out_buttons <= btn;
            last_btn    <= btn;
            out_valid   <= 1'b1;
            state       <= OFFER;
          end
          OFFER: if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mouse_motion_accumulator.sv
// Directed bench with an arithmetic reference model and per-cycle output check.
module tb_mouse_motion_accumulator;
  localparam int IC = 16;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              in_valid = 1'b0, usb_configured = 1'b0, out_ready = 1'b0;
  logic signed [7:0] in_dx = '0, in_dy = '0;
  logic [2:0]        in_buttons = '0;
  logic              out_valid, sat_flag;
  logic signed [7:0] out_x, out_y;
  logic [2:0]        out_buttons;

  int vecs = 0, errs = 0;
  bit chk_en = 1'b0;

  typedef struct { int x; int y; int b; } rep_t;
  rep_t rq[$];

  always #5 clk = ~clk;

  mouse_motion_accumulator #(.ACC_W(16), .INTERVAL_CYC(IC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_dx(in_dx), .in_dy(in_dy),
    .in_buttons(in_buttons), .usb_configured(usb_configured), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_buttons(out_buttons),
    .sat_flag(sat_flag)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: integer accumulators, clamp/saturate by plain min/max.
  int m_ax, m_ay, m_cnt, m_bx, m_by, rx, ry, m_x, m_y;
  logic [2:0] m_btn, m_last, m_b;
  bit m_tp, m_ov, m_sat, m_wrap, m_load;

  function automatic int hid(input int v);
    return (v > 127) ? 127 : ((v < -127) ? -127 : v);
  endfunction
  function automatic int sat16(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_ax = 0; m_ay = 0; m_cnt = 0; m_btn = 0; m_last = 0; m_b = 0;
      m_tp = 0; m_ov = 0; m_sat = 0; m_x = 0; m_y = 0;
    end else begin
      m_wrap = (m_cnt == IC - 1);
      m_cnt  = m_wrap ? 0 : m_cnt + 1;
      if (!usb_configured) begin
        m_ax = 0; m_ay = 0; m_tp = 0; m_sat = 0; m_last = 0; m_ov = 0;
      end else begin
        m_load = !m_ov && m_tp && (m_ax != 0 || m_ay != 0 || m_btn != m_last);
        m_bx = m_ax; m_by = m_ay;
        if (m_load) begin
          m_x = hid(m_ax); m_y = hid(m_ay); m_b = m_btn; m_last = m_btn;
          m_bx -= m_x; m_by -= m_y; m_tp = 0; m_ov = 1;
        end else if (m_ov && out_ready) m_ov = 0;
        if (in_valid) begin
          rx = m_bx + int'(in_dx); ry = m_by + int'(in_dy);
          if (rx != sat16(rx) || ry != sat16(ry)) m_sat = 1;
          m_bx = sat16(rx); m_by = sat16(ry); m_btn = in_buttons;
        end
        m_ax = m_bx; m_ay = m_by;
        if (m_wrap) m_tp = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      chk("cyc out_valid", int'(out_valid), int'(m_ov));
      chk("cyc sat_flag", int'(sat_flag), int'(m_sat));
      if (m_ov) begin
        chk("cyc out_x", int'(out_x), m_x);
        chk("cyc out_y", int'(out_y), m_y);
        chk("cyc out_buttons", int'(out_buttons), int'(m_b));
      end
    end
    if (rst_n && out_valid && out_ready)
      rq.push_back('{int'(out_x), int'(out_y), int'(out_buttons)});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse(input int dx, input int dy, input int b);
    in_valid = 1'b1; in_dx = 8'(dx); in_dy = 8'(dy); in_buttons = 3'(b);
    tick();
    in_valid = 1'b0;
  endtask

  // Flush via usb_configured, resynchronise to the interval, zero the buttons.
  task automatic quiesce();
    usb_configured = 1'b0;
    tick(2);
    while (m_cnt != 1) tick();
    usb_configured = 1'b1;
    pulse(0, 0, 0);
    rq.delete();
  endtask

  task automatic wait_ov(input string nm, input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin tick(); k++; end
    chk({nm, " out_valid timeout"}, int'(out_valid), 1);
  endtask

  function automatic rep_t rep(input int i);
    rep_t r = '{0, 0, -1};
    if (i < rq.size()) r = rq[i];
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_x", int'(out_x), 0);
    chk("reset out_y", int'(out_y), 0);
    chk("reset out_buttons", int'(out_buttons), 0);
    chk("reset sat_flag", int'(sat_flag), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single small event
    quiesce(); out_ready = 1'b1;
    pulse(5, -3, 0);
    tick(60);
    chk("t1 count", rq.size(), 1);
    chk("t1 x", rep(0).x, 5);
    chk("t1 y", rep(0).y, -3);
    chk("t1 b", rep(0).b, 0);
    chk("t1 model acc", m_ax, 0);

    // 400 counts drain over four ticks
    quiesce(); out_ready = 1'b1;
    repeat (4) pulse(100, 0, 0);
    tick(90);
    chk("t2 count", rq.size(), 4);
    chk("t2 x0", rep(0).x, 127);
    chk("t2 x1", rep(1).x, 127);
    chk("t2 x2", rep(2).x, 127);
    chk("t2 x3", rep(3).x, 19);
    chk("t2 model acc", m_ax, 0);

    // Saturation while stalled
    quiesce(); out_ready = 1'b0;
    repeat (300) pulse(127, 0, 0);
    chk("t3 sat_flag", int'(sat_flag), 1);
    chk("t3 out_valid", int'(out_valid), 1);
    chk("t3 out_x", int'(out_x), 127);
    chk("t3 model acc", m_ax, 32767);
    out_ready = 1'b1; tick();
    chk("t3 released x", rep(0).x, 127);
    out_ready = 1'b0;
    quiesce();
    chk("t3 sat cleared", int'(sat_flag), 0);

    // Button-only report, then no repeat for identical buttons
    out_ready = 1'b1;
    pulse(0, 0, 1);
    tick(60);
    chk("t4 count", rq.size(), 1);
    chk("t4 x", rep(0).x, 0);
    chk("t4 y", rep(0).y, 0);
    chk("t4 b", rep(0).b, 1);
    rq.delete();
    pulse(0, 0, 1); tick(3); pulse(0, 0, 1);
    tick(60);
    chk("t4 no repeat", rq.size(), 0);

    // Stall with motion arriving during OFFER
    quiesce(); out_ready = 1'b0;
    pulse(10, 0, 0);
    wait_ov("t5", 40);
    tick(5); pulse(10, 0, 0); tick(34);
    chk("t5 stalled x", int'(out_x), 10);
    chk("t5 stalled valid", int'(out_valid), 1);
    chk("t5 none yet", rq.size(), 0);
    out_ready = 1'b1;
    tick(60);
    chk("t5 count", rq.size(), 2);
    chk("t5 x0", rep(0).x, 10);
    chk("t5 x1", rep(1).x, 10);

    // Delta on the load cycle goes to the residual
    quiesce(); out_ready = 1'b1;
    pulse(5, 0, 0);
    while (m_cnt != 0) tick();
    pulse(7, 0, 0);
    tick(40);
    chk("t5b count", rq.size(), 2);
    chk("t5b x0", rep(0).x, 5);
    chk("t5b x1", rep(1).x, 7);

    // Deconfigure during OFFER
    quiesce(); out_ready = 1'b0;
    pulse(50, 0, 0);
    wait_ov("t6", 40);
    usb_configured = 1'b0;
    tick();
    chk("t6 valid dropped", int'(out_valid), 0);
    chk("t6 sat", int'(sat_flag), 0);
    chk("t6 model acc", m_ax, 0);
    tick(3);
    usb_configured = 1'b1; out_ready = 1'b1; rq.delete();
    tick(60);
    chk("t6 no report", rq.size(), 0);

    // Asynchronous reset mid-offer
    out_ready = 1'b0;
    pulse(20, 0, 0);
    wait_ov("t7", 40);
    chk("t7 offered x", int'(out_x), 20);
    #1 rst_n = 1'b0;
    #1;
    chk("t7 rst out_valid", int'(out_valid), 0);
    chk("t7 rst out_x", int'(out_x), 0);
    chk("t7 rst out_buttons", int'(out_buttons), 0);
    chk("t7 rst sat", int'(sat_flag), 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
